// File: rtl/txll_rdctrl.sv
// -----------------------------------------------------------------------------
// txll_rdctrl
//
// Purpose:
//   Pulls framed dwords out of a first-word-fall-through TX FIFO and presents
//   them to the link layer through a single output register stage. Frames
//   are checked while they stream through: a word without sof outside a
//   frame is discarded, an sof arriving inside a frame closes the open frame
//   with an aborted null beat, and a frame longer than C_MAX_DW dwords is
//   closed with an aborted beat while the rest of it is dropped up to and
//   including its eof.
//
// Ports:
//   sys_clk       in   clock, all logic on the rising edge
//   sys_rst       in   asynchronous active-high reset
//   rd_do[35:0]   in   FIFO read data: [35]=sof, [34]=eof, [31:0]=data
//   rd_empty      in   FIFO empty, rd_do valid when low
//   rd_en         out  combinational pop strobe
//   rd_eof_poped  out  one-cycle pulse, the cycle after an eof word is popped
//   tx_data       out  link-layer dword
//   tx_sof        out  start-of-frame marker (qualified by tx_valid)
//   tx_eof        out  end-of-frame marker (qualified by tx_valid)
//   tx_abort      out  frame abort marker (qualified by tx_valid)
//   tx_valid      out  output register holds a beat
//   tx_ready      in   link accepts the beat when tx_valid & tx_ready
//   err_nosof     out  pulse: word without sof discarded while idle
//   err_sof       out  pulse: sof inside a frame, null abort beat issued
//   err_len       out  pulse: frame exceeded C_MAX_DW dwords
//
// States:
//   state | meaning
//   IDLE  | between frames, waiting for an sof word
//   FRAME | inside a frame, forwarding words until eof
//   DROP  | frame was cut for length, discarding words up to eof
// -----------------------------------------------------------------------------
module txll_rdctrl #(
  parameter int C_MAX_DW = 2049
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [35:0] rd_do,
  input  logic        rd_empty,
  output logic        rd_en,
  output logic        rd_eof_poped,
  output logic [31:0] tx_data,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic        tx_abort,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        err_nosof,
  output logic        err_sof,
  output logic        err_len
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    DROP  = 2'd2
  } state_t;

  // The dword counter is 12 bits wide, so the limit must fit in 12 bits.
  localparam logic [11:0] MAX_DW = 12'(C_MAX_DW);

  state_t      state;
  logic [11:0] dw_cnt;
  logic [11:0] dw_cnt_inc;

  logic        in_sof;
  logic        in_eof;
  logic        word_ok;
  logic        reg_free;
  logic        len_err;
  logic        load_word;
  logic        load_null;

  // rd_do[33:32] carry no meaning for this block.
  logic        unused_rd_bits;
  assign unused_rd_bits = ^rd_do[33:32];

  assign in_sof   = rd_do[35];
  assign in_eof   = rd_do[34];
  // Gating with sys_rst keeps rd_en low for the whole reset window.
  assign word_ok  = !rd_empty && !sys_rst;
  assign reg_free = !tx_valid || tx_ready;

  // Saturating increment so an over-long frame never wraps the count.
  assign dw_cnt_inc = (dw_cnt == 12'hFFF) ? dw_cnt : dw_cnt + 12'd1;

  // A non-eof word that would push the count past the limit terminates the
  // frame. An eof word at that point still closes the frame normally.
  assign len_err = (state == FRAME) && !in_sof && !in_eof && (dw_cnt >= MAX_DW);

  always_comb begin
    rd_en     = 1'b0;
    load_word = 1'b0;
    load_null = 1'b0;
    unique case (state)
      IDLE: begin
        if (word_ok) begin
          if (!in_sof) begin
            // Stray word: discarded, no output space needed.
            rd_en = 1'b1;
          end else if (reg_free) begin
            rd_en     = 1'b1;
            load_word = 1'b1;
          end
        end
      end
      FRAME: begin
        if (word_ok && reg_free) begin
          if (in_sof) begin
            // Leave the sof word in the FIFO; it opens the next frame.
            load_null = 1'b1;
          end else begin
            rd_en     = 1'b1;
            load_word = 1'b1;
          end
        end
      end
      DROP: begin
        if (word_ok && !in_sof) begin
          rd_en = 1'b1;
        end
      end
      default: begin
        rd_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= IDLE;
      dw_cnt       <= 12'd0;
      tx_valid     <= 1'b0;
      tx_data      <= 32'd0;
      tx_sof       <= 1'b0;
      tx_eof       <= 1'b0;
      tx_abort     <= 1'b0;
      rd_eof_poped <= 1'b0;
      err_nosof    <= 1'b0;
      err_sof      <= 1'b0;
      err_len      <= 1'b0;
    end else begin
      rd_eof_poped <= rd_en && in_eof;
      err_nosof    <= (state == IDLE) && rd_en && !in_sof;
      err_sof      <= load_null;
      err_len      <= load_word && len_err;

      // Output register: only touched when free, so a stalled beat holds.
      if (reg_free) begin
        tx_valid <= load_word || load_null;
        if (load_word) begin
          tx_data  <= rd_do[31:0];
          tx_sof   <= (state == IDLE);
          tx_eof   <= in_eof || len_err;
          tx_abort <= len_err;
        end else if (load_null) begin
          tx_data  <= 32'd0;
          tx_sof   <= 1'b0;
          tx_eof   <= 1'b1;
          tx_abort <= 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          if (load_word) begin
            dw_cnt <= 12'd1;
            if (!in_eof) begin
              state <= FRAME;
            end
          end
        end
        FRAME: begin
          if (load_null) begin
            state <= IDLE;
          end else if (load_word) begin
            dw_cnt <= dw_cnt_inc;
            if (len_err) begin
              state <= DROP;
            end else if (in_eof) begin
              state <= IDLE;
            end
          end
        end
        DROP: begin
          if (word_ok && (in_sof || in_eof)) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_txll_rdctrl.sv
module tb_txll_rdctrl;

  localparam int MAXDW = 2049;

  logic        sys_clk;
  logic        sys_rst;
  logic [35:0] rd_do;
  logic        rd_empty;
  logic        rd_en;
  logic        rd_eof_poped;
  logic [31:0] tx_data;
  logic        tx_sof;
  logic        tx_eof;
  logic        tx_abort;
  logic        tx_valid;
  logic        tx_ready;
  logic        err_nosof;
  logic        err_sof;
  logic        err_len;

  txll_rdctrl #(.C_MAX_DW(MAXDW)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .rd_do        (rd_do),
    .rd_empty     (rd_empty),
    .rd_en        (rd_en),
    .rd_eof_poped (rd_eof_poped),
    .tx_data      (tx_data),
    .tx_sof       (tx_sof),
    .tx_eof       (tx_eof),
    .tx_abort     (tx_abort),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .err_nosof    (err_nosof),
    .err_sof      (err_sof),
    .err_len      (err_len)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Stream under test and the expected result from the reference model.
  logic [35:0] src_q[$];
  logic [34:0] exp_q[$];   // {sof, eof, abort, data}
  int exp_nosof, exp_sof, exp_len, exp_eofpop;
  int acc_first, acc_last, acc_got;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [35:0] mk(input logic s, input logic e, input logic [31:0] d);
    logic [1:0] junk;
    junk = 2'($urandom);
    return {s, e, junk, d};
  endfunction

  function automatic logic [40:0] all_out();
    return {rd_en, rd_eof_poped, tx_data, tx_sof, tx_eof, tx_abort, tx_valid,
            err_nosof, err_sof, err_len};
  endfunction

  // Frame-level reference: walks the word stream applying the framing rules.
  task automatic model_build();
    logic [35:0] w;
    int i, st, cnt;
    i = 0; st = 0; cnt = 0;
    exp_q.delete();
    exp_nosof = 0; exp_sof = 0; exp_len = 0; exp_eofpop = 0;
    while (i < src_q.size()) begin
      w = src_q[i];
      if (st == 0) begin
        if (!w[35]) exp_nosof++;
        else begin
          exp_q.push_back({1'b1, w[34], 1'b0, w[31:0]});
          cnt = 1;
          if (!w[34]) st = 1;
        end
        if (w[34]) exp_eofpop++;
        i++;
      end else if (st == 1) begin
        if (w[35]) begin
          exp_q.push_back({3'b011, 32'h0});
          exp_sof++;
          st = 0;
        end else begin
          if (!w[34] && cnt + 1 > MAXDW) begin
            exp_q.push_back({3'b011, w[31:0]});
            exp_len++;
            st = 2;
          end else begin
            exp_q.push_back({1'b0, w[34], 1'b0, w[31:0]});
            cnt++;
            if (w[34]) begin
              st = 0;
              exp_eofpop++;
            end
          end
          i++;
        end
      end else begin
        if (w[35]) st = 0;
        else begin
          if (w[34]) begin
            exp_eofpop++;
            st = 0;
          end
          i++;
        end
      end
    end
  endtask

  task automatic run_stream(input string tag, input int ready_pct, input int empty_pct,
                            input int stall_beat);
    int cyc, budget, nosof, esof, elen, eofp, stall_left;
    bit stalled_once, prev_stall, stalling;
    logic [34:0] prev_beat, cur;
    cyc = 0; nosof = 0; esof = 0; elen = 0; eofp = 0; stall_left = 0;
    stalled_once = 0; prev_stall = 0; prev_beat = '0;
    acc_first = -1; acc_last = -1; acc_got = 0;
    model_build();
    budget = 8 * src_q.size() + 60;
    while ((src_q.size() != 0 || tx_valid) && cyc < budget) begin
      @(negedge sys_clk);
      rd_empty = (src_q.size() == 0) || ($urandom_range(99) < empty_pct);
      rd_do    = (src_q.size() != 0) ? src_q[0] : {$urandom_range(15), $urandom()};
      if (stall_beat >= 0 && acc_got == stall_beat && tx_valid && !stalled_once) begin
        stall_left   = 4;
        stalled_once = 1;
      end
      stalling = (stall_left > 0);
      if (stalling) begin
        tx_ready = 1'b0;
        stall_left--;
      end else begin
        tx_ready = ($urandom_range(99) < ready_pct);
      end
      #1;
      nosof += int'(err_nosof); esof += int'(err_sof);
      elen  += int'(err_len);   eofp += int'(rd_eof_poped);
      cur = {tx_sof, tx_eof, tx_abort, tx_data};
      if (rd_empty) chk({tag, "_rd_en_when_empty"}, rd_en, 1'b0);
      if (stalling) chk({tag, "_rd_en_while_stalled"}, rd_en, 1'b0);
      if (prev_stall) begin
        chk({tag, "_valid_held"}, tx_valid, 1'b1);
        chk({tag, "_beat_held"}, cur, prev_beat);
      end
      if (rd_en && src_q.size() != 0) void'(src_q.pop_front());
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk({tag, "_extra_beat"}, cur, 35'h7_FFFF_FFFF);
        else chk({tag, "_beat"}, cur, exp_q.pop_front());
        if (acc_first < 0) acc_first = cyc;
        acc_last = cyc;
        acc_got++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_beat  = cur;
      cyc++;
    end
    chk({tag, "_completed_in_budget"}, (src_q.size() == 0 && !tx_valid), 1'b1);
    // Collect pulses registered on the final edges.
    repeat (3) begin
      @(negedge sys_clk);
      rd_empty = 1'b1;
      tx_ready = 1'b1;
      #1;
      nosof += int'(err_nosof); esof += int'(err_sof);
      elen  += int'(err_len);   eofp += int'(rd_eof_poped);
    end
    chk({tag, "_missing_beats"}, exp_q.size(), 0);
    chk({tag, "_err_nosof_count"}, nosof, exp_nosof);
    chk({tag, "_err_sof_count"}, esof, exp_sof);
    chk({tag, "_err_len_count"}, elen, exp_len);
    chk({tag, "_eof_poped_count"}, eofp, exp_eofpop);
    src_q.delete();
  endtask

  task automatic gen_random(input int n_frames);
    int kind, len;
    for (int f = 0; f < n_frames; f++) begin
      kind = $urandom_range(99);
      len  = $urandom_range(1, 6);
      if (kind < 12) begin
        src_q.push_back(mk(1'b0, 1'($urandom), $urandom()));
      end else if (kind < 24) begin
        // Frame cut short: no eof before the next sof.
        src_q.push_back(mk(1'b1, 1'b0, $urandom()));
        for (int k = 1; k < len + 1; k++) src_q.push_back(mk(1'b0, 1'b0, $urandom()));
      end else begin
        src_q.push_back(mk(1'b1, len == 1, $urandom()));
        for (int k = 1; k < len; k++) src_q.push_back(mk(1'b0, k == len - 1, $urandom()));
      end
    end
    src_q.push_back(mk(1'b1, 1'b0, $urandom()));
    src_q.push_back(mk(1'b0, 1'b1, $urandom()));
  endtask

  typedef struct {
    logic        empty;
    logic [35:0] din;
    logic        ready;
    logic        exp_rd_en;
    logic        exp_valid;
    logic [34:0] exp_beat;
    logic        exp_nosof;
    logic        exp_eofp;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{1'b1, {4'b1000, 32'h1111_1111}, 1'b1, 1'b0, 1'b0, 35'h0, 1'b0, 1'b0};
    vt[1] = '{1'b0, {4'b0000, 32'h0000_0055}, 1'b1, 1'b1, 1'b0, 35'h0, 1'b1, 1'b0};
    vt[2] = '{1'b0, {4'b1000, 32'hA0A0_0001}, 1'b1, 1'b1, 1'b1, {3'b100, 32'hA0A0_0001}, 1'b0, 1'b0};
    vt[3] = '{1'b0, {4'b1100, 32'h0000_BEEF}, 1'b1, 1'b1, 1'b1, {3'b110, 32'h0000_BEEF}, 1'b0, 1'b1};
    vt[4] = '{1'b0, {4'b0100, 32'h0000_1234}, 1'b1, 1'b1, 1'b0, 35'h0, 1'b1, 1'b1};
    vt[5] = '{1'b0, {4'b1000, 32'h5A5A_5A5A}, 1'b0, 1'b1, 1'b1, {3'b100, 32'h5A5A_5A5A}, 1'b0, 1'b0};
    vt[6] = '{1'b0, {4'b1011, 32'hFFFF_FFFF}, 1'b1, 1'b1, 1'b1, {3'b100, 32'hFFFF_FFFF}, 1'b0, 1'b0};

    sys_rst  = 1'b1;
    rd_empty = 1'b1;
    rd_do    = '0;
    tx_ready = 1'b1;

    // Single-cycle behaviour out of a fresh reset.
    for (int v = 0; v < 7; v++) begin
      @(negedge sys_clk);
      sys_rst  = 1'b1;
      rd_empty = 1'b0;
      rd_do    = {4'b1000, 32'hDEAD_0000};
      #1;
      chk($sformatf("v%0d_outputs_in_reset", v), all_out(), '0);
      @(negedge sys_clk);
      sys_rst  = 1'b0;
      rd_empty = vt[v].empty;
      rd_do    = vt[v].din;
      tx_ready = vt[v].ready;
      #1;
      chk($sformatf("v%0d_rd_en", v), rd_en, vt[v].exp_rd_en);
      @(posedge sys_clk);
      #1;
      rd_empty = 1'b1;
      chk($sformatf("v%0d_tx_valid", v), tx_valid, vt[v].exp_valid);
      if (vt[v].exp_valid)
        chk($sformatf("v%0d_beat", v), {tx_sof, tx_eof, tx_abort, tx_data}, vt[v].exp_beat);
      chk($sformatf("v%0d_err_nosof", v), err_nosof, vt[v].exp_nosof);
      chk($sformatf("v%0d_eof_poped", v), rd_eof_poped, vt[v].exp_eofp);
    end

    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst  = 1'b0;
    tx_ready = 1'b1;

    // Three-word frame at full rate: three back-to-back beats.
    src_q = '{mk(1, 0, 32'hD000_0000), mk(0, 0, 32'hD000_0001), mk(0, 1, 32'hD000_0002)};
    run_stream("frame3", 100, 0, -1);
    chk("frame3_beat_count", acc_got, 3);
    chk("frame3_back_to_back", acc_last - acc_first, 2);

    // Same frame, link stalls four cycles while D1 is presented.
    src_q = '{mk(1, 0, 32'hD000_0000), mk(0, 0, 32'hD000_0001), mk(0, 1, 32'hD000_0002)};
    run_stream("stall", 100, 0, 1);
    chk("stall_beat_count", acc_got, 3);

    // Stray word before a valid frame.
    src_q = '{mk(0, 0, 32'h0000_0055), mk(1, 0, 32'hC000_0000), mk(0, 1, 32'hC000_0001)};
    run_stream("stray", 100, 0, -1);
    chk("stray_beat_count", acc_got, 2);

    // sof inside a frame: A0, A1, null abort, then frame B.
    src_q = '{mk(1, 0, 32'hAAAA_0000), mk(0, 0, 32'hAAAA_0001),
              mk(1, 0, 32'hBBBB_0000), mk(0, 1, 32'hBBBB_0001)};
    run_stream("early_sof", 100, 0, -1);
    chk("early_sof_beat_count", acc_got, 5);

    // Over-long frame: 2060 words against a 2049 limit.
    src_q.push_back(mk(1, 0, 32'h0));
    for (int k = 1; k < 2060; k++) src_q.push_back(mk(0, k == 2059, k));
    run_stream("long", 100, 0, -1);
    chk("long_beat_count", acc_got, 2050);

    // Random traffic with FIFO gaps and link back-pressure.
    gen_random(40);
    run_stream("rand_a", 60, 20, -1);
    gen_random(40);
    run_stream("rand_b", 30, 40, -1);
    gen_random(40);
    run_stream("rand_c", 100, 0, -1);

    // Reset in the middle of a frame while a beat is stalled.
    @(negedge sys_clk);
    rd_empty = 1'b0;
    rd_do    = {4'b1000, 32'hF00D_0000};
    tx_ready = 1'b0;
    @(posedge sys_clk);
    #1;
    rd_do = {4'b0000, 32'hF00D_0001};
    chk("midreset_valid_before", tx_valid, 1'b1);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("midreset_outputs_cleared", all_out(), '0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst  = 1'b0;
    rd_empty = 1'b1;
    tx_ready = 1'b1;
    src_q = '{mk(0, 0, 32'hF00D_0001), mk(0, 1, 32'hF00D_0002),
              mk(1, 0, 32'hE000_0000), mk(0, 1, 32'hE000_0001)};
    run_stream("after_reset", 100, 0, -1);
    chk("after_reset_beat_count", acc_got, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/txll_rdctrl.md
TXLL_RDCTRL -- requirements
Module: txll_rdctrl

Interface
REQ-001 SHALL have parameter C_MAX_DW, default 2049, the maximum dwords per frame, including the SOF dword.
REQ-002 SHALL have port sys_clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-003 SHALL have port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port rd_do, input, 36 bits: TX FIFO read data, first-word-fall-through; [35]=sof, [34]=eof, [31:0]=data, [33:32] ignored.
REQ-005 SHALL have port rd_empty, input, 1 bit: FIFO empty; rd_do is valid when low.
REQ-006 SHALL have port rd_en, output, 1 bit: combinational pop strobe; it never asserts while rd_empty=1.
REQ-007 SHALL have port rd_eof_poped, output, 1 bit: one-cycle pulse, registered, on the cycle after an eof word is popped.
REQ-008 SHALL have port tx_data, output, 32 bits: link-layer dword.
REQ-009 SHALL have ports tx_sof, tx_eof and tx_abort, output, 1 bit each: frame markers, qualified by tx_valid.
REQ-010 SHALL have port tx_valid, output, 1 bit: the output register holds a beat.
REQ-011 SHALL have port tx_ready, input, 1 bit: the link accepts the beat when tx_valid=1 and tx_ready=1.
REQ-012 SHALL have ports err_nosof, err_sof and err_len, output, 1 bit each: one-cycle registered error pulses.

Function
REQ-013 SHALL use a single output register stage; the register is free when tx_valid=0 or tx_ready=1.
REQ-014 SHALL run a state machine with states IDLE, FRAME and DROP.
REQ-015 SHALL, in IDLE with rd_empty=0 and rd_do[35]=0: pop the word, discard it, pulse err_nosof, and stay in IDLE; free space in the output register is not required.
REQ-016 SHALL, in IDLE with rd_empty=0, rd_do[35]=1 and the register free: pop the word, load it with tx_sof=1, tx_eof=rd_do[34], tx_abort=0, and set the dword count to 1.
REQ-017 SHALL, after loading the word in REQ-016, go to FRAME, or stay in IDLE when eof=1.
REQ-018 SHALL, in FRAME with a non-sof word and the register free: pop the word, load it with tx_sof=0 and tx_eof=rd_do[34], and increment the count.
REQ-019 SHALL, after loading the word in REQ-018, return to IDLE when eof=1.
REQ-020 SHALL, in FRAME with rd_do[35]=1 and the register free, not pop; instead load a null beat (tx_data=0, tx_eof=1, tx_abort=1), pulse err_sof, and go to IDLE, where the sof word starts the next frame.
REQ-021 SHALL, in FRAME, when a non-eof word would make the count exceed C_MAX_DW: pop it, load it with tx_eof=1 and tx_abort=1, pulse err_len, and go to DROP.
REQ-022 SHALL, in DROP, pop and discard every word regardless of the register; an eof word returns the machine to IDLE.
REQ-023 SHALL, in DROP, go to IDLE without popping when a sof word arrives.
REQ-024 SHALL hold the count in a 12-bit counter that saturates and never wraps.
REQ-025 SHALL keep tx_data, tx_sof, tx_eof and tx_abort stable while tx_valid=1 and tx_ready=0.
REQ-026 SHALL have a fall-through latency of 1 cycle from rd_en to tx_valid.
REQ-027 SHALL give full throughput of 1 beat/cycle when tx_ready=1.
REQ-028 SHALL, when the register is loaded and drained in the same cycle, keep tx_valid=1 with the new beat.
REQ-029 SHALL assert rd_eof_poped for every popped eof word, including words dropped in DROP and single-word frames.

Reset
REQ-030 SHALL, while sys_rst=1, force state=IDLE, count=0, tx_valid=0, tx_data=0, all tx_* markers=0, rd_eof_poped=0 and all err_* outputs=0.
REQ-031 SHALL, when reset is asserted mid-frame, lose the in-flight beat; after reset, words without sof are dropped under REQ-015.
REQ-032 SHALL assert no rd_en during reset.

Verification
REQ-033 SHALL cover a 3-word frame (sof D0, D1, eof D2) with tx_ready=1 -> tx_valid for 3 consecutive cycles, tx_sof on D0 only, tx_eof on D2, and rd_eof_poped on 1 cycle.
REQ-034 SHALL cover the same frame with tx_ready low for 4 cycles on D1 -> D1 held stable, rd_en=0 while stalled, no loss or duplication.
REQ-035 SHALL cover a stray 0x0000_0055 word without sof in IDLE followed by a valid frame -> err_nosof pulse, stray word never on tx, frame delivered intact.
REQ-036 SHALL cover sof A, A1, then sof B -> beats A0, A1, null (tx_eof=1, tx_abort=1), then frame B; err_sof=1 once.
REQ-037 SHALL cover a 2060-word frame with C_MAX_DW=2049 -> word 2050 carries tx_eof=1 and tx_abort=1, err_len pulse, words 2051-2060 dropped, rd_eof_poped at word 2060, IDLE.
REQ-038 SHALL cover sys_rst asserted mid-frame with tx_valid=1 -> all outputs 0 immediately (asynchronous); the next sof frame is received cleanly.
